// File: rtl/ifm_ctrl_pkg.sv
// Shared constants and read-state encoding for the IFM chunk ping-pong controller.
`ifndef MEM_SIZE
`define MEM_SIZE 32
`endif
`ifndef BUS_SIZE
`define BUS_SIZE 4
`endif
`ifndef COMPUTE_UNIT_NUM
`define COMPUTE_UNIT_NUM 4
`endif

package ifm_ctrl_pkg;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_START = 2'd1,
    R_RUN   = 2'd2
  } rd_state_e;

  localparam int MEM_SIZE_DEF    = `MEM_SIZE;
  localparam int BUS_SIZE_DEF    = `BUS_SIZE;
  localparam int CU_NUM_DEF      = `COMPUTE_UNIT_NUM;
  localparam int WR_CYC_NUM_DEF  = MEM_SIZE_DEF / BUS_SIZE_DEF;
  localparam int WR_CNT_W_DEF    = $clog2(WR_CYC_NUM_DEF);
  localparam int CHUNK_CNT_W_DEF = 16;

endpackage

// File: rtl/cu_done_tracker.sv
// Sticky per-unit done mask; reports when every compute unit has finished the chunk.
module cu_done_tracker #(
  parameter int COMPUTE_UNIT_NUM = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        clr_i,
  input  logic                        en_i,
  input  logic [COMPUTE_UNIT_NUM-1:0] done_i,
  output logic                        all_done_o
);

  logic [COMPUTE_UNIT_NUM-1:0] mask_q;

  // Accumulate done pulses while the chunk runs; duplicates are harmless.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mask_q <= '0;
    end else if (clr_i) begin
      mask_q <= '0;
    end else if (en_i) begin
      mask_q <= mask_q | done_i;
    end
  end

  // Include this cycle's pulses so the release happens on the final done.
  assign all_done_o = en_i && (&(mask_q | done_i));

endmodule

// File: rtl/ifm_chunk_pingpong_ctrl.sv
// Double-buffered IFM chunk sequencer: fills the free buffer, starts the
// compute array on a full one, and frees it once every unit is done.
module ifm_chunk_pingpong_ctrl
  import ifm_ctrl_pkg::*;
#(
  parameter int MEM_SIZE         = MEM_SIZE_DEF,
  parameter int BUS_SIZE         = BUS_SIZE_DEF,
  parameter int COMPUTE_UNIT_NUM = CU_NUM_DEF,
  parameter int WR_CYC_NUM       = MEM_SIZE / BUS_SIZE,
  parameter int CHUNK_CNT_W      = CHUNK_CNT_W_DEF
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          flush_i,
  input  logic [CHUNK_CNT_W-1:0]        num_chunks_i,
  input  logic                          src_valid_i,
  output logic                          src_ready_o,
  output logic                          wr_valid_o,
  output logic                          wr_sel_o,
  output logic [$clog2(WR_CYC_NUM)-1:0] wr_count_o,
  input  logic                          start_en_i,
  output logic                          chunk_start_o,
  output logic                          rd_sel_o,
  input  logic [COMPUTE_UNIT_NUM-1:0]   cu_done_i,
  output logic [1:0]                    buf_full_o,
  output logic [CHUNK_CNT_W-1:0]        chunk_idx_o,
  output logic                          frame_done_o
);

  localparam int WR_CNT_W = $clog2(WR_CYC_NUM);
  localparam logic [WR_CNT_W-1:0] LAST_BEAT = WR_CNT_W'(WR_CYC_NUM - 1);

  logic                   wr_sel_q, rd_sel_q;
  logic [WR_CNT_W-1:0]    wr_cnt_q;
  logic [1:0]             full_q, full_set, full_clr;
  rd_state_e              state_q;
  logic                   chunk_start_q, frame_done_q, rel_q;
  logic [CHUNK_CNT_W-1:0] chunk_idx_q, num_chunks_q;
  logic                   wr_fire, last_beat, all_done, release_w;

  assign src_ready_o = !full_q[wr_sel_q];
  assign wr_fire     = src_valid_i && src_ready_o;
  assign wr_valid_o  = wr_fire;
  assign last_beat   = wr_fire && (wr_cnt_q == LAST_BEAT);
  assign release_w   = (state_q == R_RUN) && all_done;

  cu_done_tracker #(
    .COMPUTE_UNIT_NUM(COMPUTE_UNIT_NUM)
  ) u_tracker (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (flush_i || release_w),
    .en_i      (state_q == R_RUN),
    .done_i    (cu_done_i),
    .all_done_o(all_done)
  );

  // Writer marks a buffer full, reader frees one; they never hit the same bit.
  always_comb begin
    full_set = '0;
    full_clr = '0;
    if (last_beat) full_set[wr_sel_q] = 1'b1;
    if (release_w) full_clr[rd_sel_q] = 1'b1;
  end

  // Write side: beat counter, buffer select and full flags.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_sel_q <= 1'b0;
      wr_cnt_q <= '0;
      full_q   <= '0;
    end else if (flush_i) begin
      wr_sel_q <= 1'b0;
      wr_cnt_q <= '0;
      full_q   <= '0;
    end else begin
      if (wr_fire) begin
        if (last_beat) begin
          wr_cnt_q <= '0;
          wr_sel_q <= ~wr_sel_q;
        end else begin
          wr_cnt_q <= wr_cnt_q + 1'b1;
        end
      end
      full_q <= (full_q | full_set) & ~full_clr;
    end
  end

  // Read FSM: start pulse, run until all units done, then release the buffer.
  // rel_q holds off a restart for one cycle after a release.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= R_IDLE;
      rd_sel_q      <= 1'b0;
      chunk_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      rel_q         <= 1'b0;
      chunk_idx_q   <= '0;
      num_chunks_q  <= CHUNK_CNT_W'(1);
    end else if (flush_i) begin
      state_q       <= R_IDLE;
      rd_sel_q      <= 1'b0;
      chunk_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      rel_q         <= 1'b0;
      chunk_idx_q   <= '0;
      num_chunks_q  <= CHUNK_CNT_W'(1);
    end else begin
      chunk_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      rel_q         <= 1'b0;
      case (state_q)
        R_IDLE: begin
          if (chunk_idx_q == '0)
            num_chunks_q <= (num_chunks_i == '0) ? CHUNK_CNT_W'(1) : num_chunks_i;
          if (!rel_q && full_q[rd_sel_q] && start_en_i) begin
            state_q       <= R_START;
            chunk_start_q <= 1'b1;
          end
        end
        R_START: state_q <= R_RUN;
        R_RUN: begin
          if (all_done) begin
            state_q  <= R_IDLE;
            rd_sel_q <= ~rd_sel_q;
            rel_q    <= 1'b1;
            if (chunk_idx_q == num_chunks_q - 1'b1) begin
              chunk_idx_q  <= '0;
              frame_done_q <= 1'b1;
            end else begin
              chunk_idx_q <= chunk_idx_q + 1'b1;
            end
          end
        end
        default: state_q <= R_IDLE;
      endcase
    end
  end

  assign wr_sel_o      = wr_sel_q;
  assign wr_count_o    = wr_cnt_q;
  assign buf_full_o    = full_q;
  assign rd_sel_o      = rd_sel_q;
  assign chunk_start_o = chunk_start_q;
  assign chunk_idx_o   = chunk_idx_q;
  assign frame_done_o  = frame_done_q;

endmodule

// File: tb/tb_ifm_chunk_pingpong_ctrl.sv
// Self-checking bench: behavioural buffer/consumer model compared every cycle.
module tb_ifm_chunk_pingpong_ctrl;

  localparam int N   = 8;
  localparam int CU  = 3;
  localparam int CW  = 16;
  localparam logic [CU-1:0] ALL = '1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic [CW-1:0] num_chunks = 16'd1;
  logic          src_valid = 1'b0;
  logic          start_en = 1'b0;
  logic [CU-1:0] cu_done = '0;
  logic          src_ready, wr_valid, wr_sel, chunk_start, rd_sel, frame_done;
  logic [2:0]    wr_count;
  logic [1:0]    buf_full;
  logic [CW-1:0] chunk_idx;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ifm_chunk_pingpong_ctrl #(
    .MEM_SIZE(32), .BUS_SIZE(4), .COMPUTE_UNIT_NUM(CU), .WR_CYC_NUM(N), .CHUNK_CNT_W(CW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .num_chunks_i(num_chunks),
    .src_valid_i(src_valid), .src_ready_o(src_ready), .wr_valid_o(wr_valid),
    .wr_sel_o(wr_sel), .wr_count_o(wr_count), .start_en_i(start_en),
    .chunk_start_o(chunk_start), .rd_sel_o(rd_sel), .cu_done_i(cu_done),
    .buf_full_o(buf_full), .chunk_idx_o(chunk_idx), .frame_done_o(frame_done)
  );

  // Model: which buffer is being filled and how many beats it holds, which
  // buffers hold a complete chunk, which buffer the consumers own, whether a
  // chunk is out to the consumers, and who has reported done.
  int       m_fill_buf, m_beats, m_read_buf, m_idx, m_nch, m_releases;
  bit [1:0] m_full;
  bit       m_inflight, m_pulse, m_cooldown, m_fdone;
  bit [CU-1:0] m_seen;

  function automatic void model_reset();
    m_fill_buf = 0; m_beats = 0; m_read_buf = 0; m_idx = 0; m_nch = 1;
    m_full = 2'b00; m_inflight = 0; m_pulse = 0; m_cooldown = 0;
    m_fdone = 0; m_seen = '0;
  endfunction

  function automatic void model_step();
    bit [1:0]    nf;
    bit [CU-1:0] seen;
    bit          just_started;
    if (flush) begin
      model_reset();
      return;
    end
    nf = m_full;
    if (src_valid && !m_full[m_fill_buf]) begin
      if (m_beats == N - 1) begin
        nf[m_fill_buf] = 1'b1;
        m_fill_buf = 1 - m_fill_buf;
        m_beats = 0;
      end else begin
        m_beats++;
      end
    end
    just_started = m_pulse;
    m_pulse = 0;
    m_fdone = 0;
    if (just_started) begin
      // consumers are only listening from the cycle after the start pulse
    end else if (m_inflight) begin
      seen = m_seen | cu_done;
      if (seen == ALL) begin
        nf[m_read_buf] = 1'b0;
        m_read_buf = 1 - m_read_buf;
        m_seen = '0;
        m_inflight = 0;
        m_cooldown = 1;
        m_releases++;
        if (m_idx == m_nch - 1) begin
          m_idx = 0;
          m_fdone = 1;
        end else begin
          m_idx++;
        end
      end else begin
        m_seen = seen;
      end
    end else begin
      if (m_idx == 0) m_nch = (num_chunks == 0) ? 1 : int'(num_chunks);
      if (m_cooldown) m_cooldown = 0;
      else if (m_full[m_read_buf] && start_en) begin
        m_pulse = 1;
        m_inflight = 1;
      end
    end
    m_full = nf;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    bit rdy;
    rdy = !m_full[m_fill_buf];
    chk("src_ready", 32'(src_ready), 32'(rdy));
    chk("wr_valid", 32'(wr_valid), 32'(src_valid && rdy));
    chk("wr_sel", 32'(wr_sel), 32'(m_fill_buf));
    chk("wr_count", 32'(wr_count), 32'(m_beats));
    chk("rd_sel", 32'(rd_sel), 32'(m_read_buf));
    chk("chunk_start", 32'(chunk_start), 32'(m_pulse));
    chk("buf_full", 32'(buf_full), 32'(m_full));
    chk("chunk_idx", 32'(chunk_idx), 32'(m_idx));
    chk("frame_done", 32'(frame_done), 32'(m_fdone));
  endtask

  task automatic drive(input bit v, input bit se, input logic [CU-1:0] cu, input bit fl);
    @(negedge clk);
    src_valid = v; start_en = se; cu_done = cu; flush = fl;
    #1;
    compare_all();
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
  endtask

  task automatic cyc(input bit v, input bit se, input logic [CU-1:0] cu, input bit fl);
    drive(v, se, cu, fl);
    tick();
  endtask

  initial begin
    int pulses;
    int extra;
    bit reached;
    logic [CU-1:0] cu;
    model_reset();
    m_releases = 0;
    repeat (3) tick();
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, '0, 0);
    chk("rst_src_ready", 32'(src_ready), 32'd1);
    chk("rst_buf_full", 32'(buf_full), 32'd0);
    tick();

    // Fill one chunk with the compute array ready.
    for (int i = 0; i < N; i++) begin
      drive(1, 1, '0, 0);
      chk("fill_wr_count", 32'(wr_count), 32'(i));
      tick();
    end
    drive(0, 1, '0, 0);
    chk("fill_full_t1", 32'(buf_full), 32'b01);
    chk("fill_nostart_t1", 32'(chunk_start), 32'd0);
    tick();
    drive(0, 1, '0, 0);
    chk("fill_start_t2", 32'(chunk_start), 32'd1);
    chk("fill_rd_sel_t2", 32'(rd_sel), 32'd0);
    chk("fill_wr_sel_t2", 32'(wr_sel), 32'd1);
    tick();
    cyc(0, 1, '0, 0);
    cyc(0, 1, ALL, 0);
    drive(0, 1, '0, 0);
    chk("rel_rd_sel", 32'(rd_sel), 32'd1);
    chk("rel_buf_full", 32'(buf_full), 32'd0);
    tick();

    // Backpressure: consumers never finish while three chunks are offered.
    for (int i = 0; i < 3 * N; i++) cyc(1, 1, '0, 0);
    drive(1, 1, '0, 0);
    chk("bp_both_full", 32'(buf_full), 32'b11);
    chk("bp_not_ready", 32'(src_ready), 32'd0);
    tick();
    drive(1, 1, ALL, 0);
    chk("bp_release_cycle_ready", 32'(src_ready), 32'd0);
    tick();
    drive(1, 1, '0, 0);
    chk("bp_after_rd_sel", 32'(rd_sel), 32'd0);
    chk("bp_after_ready", 32'(src_ready), 32'd1);
    tick();

    // Staggered done pulses: release only after the last unit reports.
    for (int c = 0; c < 25; c++) begin
      cu = (c == 10) ? 3'b001 : (c == 15) ? 3'b010 : (c == 17) ? 3'b001 :
           (c == 20) ? 3'b100 : 3'b000;
      drive(0, 1, cu, 0);
      if (c == 20) begin
        chk("stag_held_rd_sel", 32'(rd_sel), 32'd0);
        chk("stag_held_full", 32'(buf_full), 32'b01);
      end
      if (c == 21) begin
        chk("stag_rel_rd_sel", 32'(rd_sel), 32'd1);
        chk("stag_rel_full", 32'(buf_full), 32'b00);
      end
      tick();
    end

    // Frame of three chunks with continuous traffic.
    cyc(0, 0, '0, 1);
    num_chunks = 16'd3;
    m_releases = 0;
    pulses = 0;
    extra = 0;
    reached = 0;
    for (int c = 0; c < 300 && extra < 3; c++) begin
      drive(1, 1, ALL, 0);
      if (frame_done) pulses++;
      tick();
      if (m_releases >= 3) begin
        reached = 1;
        extra++;
      end
    end
    chk("frame_reached", 32'(reached), 32'd1);
    chk("frame_pulses", 32'(pulses), 32'd1);

    // Flush in the middle of a fill while a chunk is running.
    cyc(0, 0, '0, 1);
    num_chunks = 16'd1;
    for (int i = 0; i < N; i++) cyc(1, 1, '0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 1, '0, 0);
    cyc(1, 1, '0, 1);
    drive(0, 0, '0, 0);
    chk("flush_ready", 32'(src_ready), 32'd1);
    chk("flush_wr_count", 32'(wr_count), 32'd0);
    chk("flush_wr_sel", 32'(wr_sel), 32'd0);
    chk("flush_rd_sel", 32'(rd_sel), 32'd0);
    chk("flush_full", 32'(buf_full), 32'd0);
    chk("flush_start", 32'(chunk_start), 32'd0);
    tick();
    drive(1, 0, '0, 0);
    chk("post_flush_wr_count", 32'(wr_count), 32'd0);
    chk("post_flush_wr_valid", 32'(wr_valid), 32'd1);
    tick();

    // Randomised traffic, done pulses, start gating and occasional flush.
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 49) == 0) num_chunks = 16'($urandom_range(0, 4));
      cu = ($urandom_range(0, 2) == 0) ? CU'($urandom) : '0;
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, cu,
          $urandom_range(0, 149) == 0);
    end

    // Asynchronous reset between edges with a partial chunk written.
    for (int i = 0; i < N + 3; i++) cyc(1, 0, '0, 0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_wr_count", 32'(wr_count), 32'd0);
    chk("arst_buf_full", 32'(buf_full), 32'd0);
    chk("arst_wr_sel", 32'(wr_sel), 32'd0);
    chk("arst_src_ready", 32'(src_ready), 32'd1);
    model_reset();
    tick();
    cyc(0, 0, '0, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    for (int i = 0; i < 2 * N; i++) cyc(1, 1, '0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
